// File: rtl/out_port_uart_tx_pkg.sv
// Purpose: shared constants for the OUT-port UART transmitter (FSM states, byte select, widths).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package out_uart_pkg;

    // Serialiser FSM states; plain constants so older code using 2-bit states links unchanged.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Which half of the 16-bit word is on the wire; the high byte goes first.
    localparam logic BYTE_HI = 1'b0;
    localparam logic BYTE_LO = 1'b1;

    // Eight data bits per UART byte.
    localparam int BIT_IDX_W = 3;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_LEVEL_W    = $clog2(DEF_FIFO_DEPTH) + 1;

    // Occupancy needs one extra bit so that "completely full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_port_uart_tx_if.sv
// Purpose: CPU OUT-port strobe bus plus transmitter status (master = CPU side, slave = transmitter).
// Latency: n/a (wiring only).
// Backpressure: none on the bus; a write to a full FIFO is dropped and reported through overflow.
// Signals: wr_en/wr_data (OUT strobe and value), full, level, overflow, busy, tx.
interface out_port_uart_tx_if
    import out_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int LVL_W = level_w(FIFO_DEPTH);

    logic             wr_en;
    logic [15:0]      wr_data;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             busy;
    logic             tx;

    modport master (
        output wr_en, wr_data,
        input  full, level, overflow, busy, tx
    );

    modport slave (
        input  wr_en, wr_data,
        output full, level, overflow, busy, tx
    );

endinterface

// File: rtl/out_port_uart_tx_fifo.sv
// Purpose: small synchronous FIFO with registered level/full and a dropped-write pulse.
// Latency: a word written on edge k is readable at rd_data (head) right after edge k.
// Backpressure: a write while full is accepted only if a pop happens on the same edge, else dropped.
// Ports: clk, rst, wr_en, wr_data, rd_en, rd_data (head word), level, full, dropped (comb pulse).
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             dropped
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [LVL_W-1:0] level_nxt;

    // When full, the slot being written is the one being popped this edge; the
    // reader takes rd_data before the edge, so the overwrite is safe.
    assign pop     = rd_en && (level != '0);
    assign push    = wr_en && (!full || pop);
    assign dropped = wr_en && full && !pop;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
        end
    end

endmodule

// File: rtl/out_port_uart_tx.sv
// Purpose: buffers 16-bit CPU OUT words and sends each as two UART 8N1 bytes, high byte first.
// Latency: word strobed on edge k into an idle, empty block drives the start bit from edge k+1.
// Backpressure: none toward the CPU; writes to a full FIFO are dropped and set sticky overflow.
// Ports: clk, rst (async, active-high), bus (slave: wr_en, wr_data, full, level, overflow, busy, tx).
module out_port_uart_tx
    import out_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,   // two UART bytes per word; other widths are not supported
    parameter int FIFO_DEPTH   = 4,    // power of two, >= 2
    parameter int CLKS_PER_BIT = 434   // >= 2
) (
    input  logic                clk,
    input  logic                rst,
    out_port_uart_tx_if.slave   bus
);
    localparam int LVL_W = level_w(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic [LVL_W-1:0]      fifo_level;
    logic                  fifo_full;
    logic                  fifo_dropped;
    logic                  fifo_rd_en;

    logic [1:0]            state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [BIT_IDX_W-1:0]  bit_idx_nxt;
    logic                  byte_sel;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [7:0]            cur_byte;
    logic                  tx_q;
    logic                  busy_q;
    logic                  overflow_q;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .dropped (fifo_dropped)
    );

    // The serialiser only pops from IDLE, so a pop never coincides with a byte in flight.
    assign fifo_rd_en  = (state == ST_IDLE) && (fifo_level != '0);
    assign cur_byte    = (byte_sel == BYTE_HI) ? shift_reg[15:8] : shift_reg[7:0];
    assign bit_idx_nxt = bit_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_sel   <= BYTE_HI;
            shift_reg  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_dropped) overflow_q <= 1'b1;

            // tx is registered, so each branch loads the level of the *next* bit
            // on the edge that ends the current one.
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_level != '0) begin
                        shift_reg <= fifo_rd_data;
                        byte_sel  <= BYTE_HI;
                        state     <= ST_START;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx_q     <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx_nxt;
                            tx_q    <= cur_byte[bit_idx_nxt];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == CNT_MAX) begin
                        baud_cnt <= '0;
                        if (byte_sel == BYTE_HI) begin
                            // Low byte follows immediately, no idle gap inside a word.
                            byte_sel <= BYTE_LO;
                            state    <= ST_START;
                            tx_q     <= 1'b0;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.level    = fifo_level;
    assign bus.full     = fifo_full;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Purpose: randomized and directed bench for out_port_uart_tx against a timing-level reference model.
// Latency: model predicts every output on every cycle, sampled on the falling clock edge.
// Backpressure: model drops writes to a full queue unless a pop happens on the same edge.
module tb_out_port_uart_tx;
    import out_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 20 * CPB;   // busy cycles per word

    logic clk = 1'b0;
    logic rst = 1'b1;

    out_port_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

    out_port_uart_tx #(
        .DATA_WIDTH   (16),
        .FIFO_DEPTH   (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a word queue plus a countdown of remaining busy cycles.
    logic [15:0] m_q[$];
    int          m_rem  = 0;
    bit          m_ovf  = 1'b0;
    logic [15:0] m_word = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Line level from position inside the 20-bit frame pair: start, 8 data LSB first, stop.
    function automatic bit m_tx();
        int t, pos, b;
        logic [7:0] byt;
        if (m_rem == 0) return 1'b1;
        t   = FRAME - m_rem;
        pos = t / CPB;
        b   = pos % 10;
        byt = (pos < 10) ? m_word[15:8] : m_word[7:0];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byt[b-1];
    endfunction

    task automatic model_edge(input logic w, input logic [15:0] d);
        bit pop;
        pop = (m_rem == 0) && (m_q.size() > 0);
        if (pop) begin
            m_word = m_q.pop_front();
            m_rem  = FRAME;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (w) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rem = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("tx",       32'(bus_if.tx),       32'(m_tx()));
        check("busy",     32'(bus_if.busy),     32'(m_rem > 0));
        check("level",    32'(bus_if.level),    32'(m_q.size()));
        check("full",     32'(bus_if.full),     32'(m_q.size() == DEPTH));
        check("overflow", 32'(bus_if.overflow), 32'(m_ovf));
    endtask

    // Called at a falling edge; applies inputs across the next rising edge.
    task automatic step(input logic w, input logic [15:0] d);
        bus_if.wr_en   = w;
        bus_if.wr_data = d;
        @(posedge clk);
        model_edge(w, d);
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        check_outputs();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        check_outputs();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((m_rem != 0 || m_q.size() != 0) && n < 2000) begin
            step(1'b0, 16'h0);
            n++;
        end
        step(1'b0, 16'h0);
        check({tag, "_idle"}, 32'(bus_if.busy), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int n;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Single word 0x0008: start bit right after the next edge, 80 busy cycles.
        step(1'b0, 16'h0);
        step(1'b1, 16'h0008);
        check("single_level_k", 32'(bus_if.level), 32'(1));
        step(1'b0, 16'h0);
        check("single_txfall", 32'(bus_if.tx), 32'(0));
        check("single_level_k1", 32'(bus_if.level), 32'(0));
        busy_cnt = 1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 16'h0);
            if (bus_if.busy) busy_cnt++;
        end
        check("single_busy_cycles", 32'(busy_cnt), 32'(FRAME));

        // Overflow: six back-to-back strobes while idle; the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 16'(i));
            if (i == 5) check("ovf_level4", 32'(bus_if.level), 32'(4));
            if (i == 5) check("ovf_not_yet", 32'(bus_if.overflow), 32'(0));
        end
        check("ovf_set", 32'(bus_if.overflow), 32'(1));
        drain("ovf");
        check("ovf_sticky", 32'(bus_if.overflow), 32'(1));
        sync_reset();

        // Write on full with a simultaneous pop at the end of a frame.
        for (int i = 0; i < 5; i++) step(1'b1, 16'h1000 + 16'(i));
        check("fp_full", 32'(bus_if.full), 32'(1));
        n = 0;
        while (m_rem != 0 && n < 200) begin
            step(1'b0, 16'h0);
            n++;
        end
        step(1'b1, 16'hBEEF);
        check("fp_level", 32'(bus_if.level), 32'(4));
        check("fp_ovf", 32'(bus_if.overflow), 32'(0));
        drain("fp");
        check("fp_ovf_end", 32'(bus_if.overflow), 32'(0));

        // Back-to-back words.
        step(1'b1, 16'h1234);
        step(1'b1, 16'hABCD);
        drain("b2b");

        // Asynchronous reset during data bit 3 of the first byte of 0x00FF, two words queued.
        step(1'b1, 16'h00FF);
        step(1'b1, 16'h5555);
        step(1'b1, 16'hAAAA);
        n = 0;
        while ((FRAME - m_rem) != 4 * CPB + 1 && n < 200) begin
            step(1'b0, 16'h0);
            n++;
        end
        check("rst_mid_busy_before", 32'(bus_if.busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("rst_async_tx",    32'(bus_if.tx),    32'(1));
        check("rst_async_busy",  32'(bus_if.busy),  32'(0));
        check("rst_async_level", 32'(bus_if.level), 32'(0));
        model_reset();
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 16'h7777;
        @(posedge clk);
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        check("rst_wr_ignored", 32'(bus_if.level), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step(1'b0, 16'h0);

        // Idle stability.
        for (int i = 0; i < 1000; i++) step(1'b0, 16'h0);

        // Randomized traffic with occasional bursts that can overflow.
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 150) begin
                for (int j = 0; j < 6; j++) step(1'b1, 16'($urandom));
            end else begin
                step(1'($urandom_range(0, 24) == 0), 16'($urandom));
            end
        end
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Downstream consumer of the CPU's 16-bit OUT port.
- Each value the CPU emits with a one-cycle strobe is buffered in a small FIFO, then serialised as two UART 8N1 bytes, high byte first, on a single tx line.
- Decouples CPU execution speed from the slow serial link and flags any dropped words.

Parameters:
- DATA_WIDTH, 16, width of the OUT word; fixed at 16 (two bytes).
- FIFO_DEPTH, 4, number of buffered words; must be a power of two, at least 2.
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-high.
- wr_en  input  1  one-cycle strobe, CPU OUT value valid.
- wr_data  input  16  OUT value to transmit.
- full  output  1  FIFO holds FIFO_DEPTH words.
- level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a write was dropped.
- busy  output  1  serialiser not in IDLE.
- tx  output  1  UART line, idle high.

Behaviour:
- Reset, asynchronous: tx=1, busy=0, full=0, level=0, overflow=0. FIFO pointers are cleared, FSM goes to IDLE, counters go to 0. A frame in progress is abandoned and tx returns high immediately.
- All outputs are registered.
- FIFO write: wr_data is accepted on a rising edge when wr_en=1 and either level<FIFO_DEPTH or a pop occurs on the same edge.
  - A write while full with no simultaneous pop is dropped and sets overflow. overflow clears only on reset.
- Pop and write on the same edge: level is unchanged, and ordering is preserved (the popped word is the oldest).
- Pointers wrap modulo FIFO_DEPTH. full = (level == FIFO_DEPTH).
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE: if level>0, pop the head word into a 16-bit shift register, set byte_sel=HI, go to START. Same edge: tx<=0, busy<=1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: drive the current byte LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_sel=HI: byte_sel=LO, go to START with no gap;
    - else go to IDLE, busy<=0.
- Latency:
  - A word written at edge k is popped at edge k+1 when the serialiser is IDLE and the FIFO was empty; tx falls at edge k+1.
  - One word occupies exactly 20*CLKS_PER_BIT cycles of busy.
  - Back-to-back words: IDLE lasts one cycle between frames, so tx is high for CLKS_PER_BIT+1 cycles between the second stop bit and the next start bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state or bit change. It has no free-running phase.
- wr_en is ignored while rst=1.

Decomposition:
- Package out_uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the byte_sel constants (HI=0, LO=1);
  - the localparams for the level width and bit-counter width.
- Sub-module sync_fifo: parameterised width and depth, with ports wr_en, wr_data, rd_en, rd_data, level, full, and a dropped-write pulse. The top level holds the FSM, baud counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single word: wr_data=0x0008 strobed at edge k.
  - tx falls at edge k+1.
  - Sampled bit-centres: 0, 00000000, 1, 0, 00010000, 1 (second byte LSB first: bit3=1).
  - busy high exactly 80 cycles; level returns to 0 at edge k+1.
- Overflow: six consecutive strobes 0x0001..0x0006 at edges k..k+5 while IDLE.
  - 0x0001 popped at k+1; 0x0002..0x0005 fill the FIFO (level=4 after k+4).
  - 0x0006 dropped; overflow=1 from k+5.
  - tx carries 0x0001..0x0005 in order.
- Write on full with pop: fill to level=4 mid-frame, then strobe 0xBEEF exactly on the pop edge at the end of the frame.
  - level stays 4, overflow stays 0, 0xBEEF is transmitted last.
- Back-to-back: two words 0x1234, 0xABCD.
  - Byte sequence 0x12, 0x34, 0xAB, 0xCD.
  - tx high 4 cycles between bytes of one word, 5 cycles between words.
- Reset mid-frame: assert rst asynchronously during DATA bit 3 of 0x00FF with 2 words queued.
  - tx=1, busy=0, level=0 without waiting for a clock edge.
  - After release, nothing transmits until a new strobe.
- Idle stability: no strobes for 1000 cycles after reset → tx=1, busy=0, level=0 throughout.
